// File: rtl/mem_port_arbiter.sv
// Arbitrates N_CH SRAM-like master channels onto one SRAM port, maps kseg0/kseg1
// addresses to physical, and routes each response back after RD_LAT cycles.
module mem_port_arbiter #(
    parameter int N_CH     = 2,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0,
    parameter int MAP_EN   = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_CH-1:0]      m_req,
    input  logic [N_CH-1:0]      m_wr,
    input  logic [4*N_CH-1:0]    m_wstrb,
    input  logic [32*N_CH-1:0]   m_addr,
    input  logic [32*N_CH-1:0]   m_wdata,
    output logic [N_CH-1:0]      m_addr_ok,
    output logic [N_CH-1:0]      m_data_ok,
    output logic [31:0]          m_rdata,
    output logic                 sram_en,
    output logic [3:0]           sram_wen,
    output logic [31:0]          sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Handshake: a request is consumed in the cycle m_req[k] and m_addr_ok[k] are both
    // high; its completion is the single cycle m_data_ok[k] is high, in issue order.
    logic [CW-1:0]             r_rr_ptr;
    logic [RD_LAT-1:0]         r_tag_vld;
    logic [RD_LAT-1:0][CW-1:0] r_tag_id;

    logic          w_lo_vld, w_hi_vld, w_gnt_vld, w_gnt, w_sel_wr;
    logic [CW-1:0] w_lo_id, w_hi_id, w_gnt_id;
    logic [3:0]    w_sel_wstrb;
    logic [31:0]   w_sel_addr, w_sel_wdata;

    // lo = lowest requester overall; hi = lowest requester at or above the pointer.
    always_comb begin
        w_lo_vld = 1'b0;
        w_lo_id  = '0;
        w_hi_vld = 1'b0;
        w_hi_id  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                w_lo_vld = 1'b1;
                w_lo_id  = CW'(i);
                if (CW'(i) >= r_rr_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_id  = CW'(i);
                end
            end
        end
        if (ARB_MODE != 0 && w_hi_vld) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_hi_id;
        end else begin
            w_gnt_vld = w_lo_vld;
            w_gnt_id  = w_lo_id;
        end
    end

    assign w_gnt = w_gnt_vld & resetn;

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_wstrb = 4'b0000;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt_id == CW'(i)) begin
                w_sel_wr    = m_wr[i];
                w_sel_wstrb = m_wstrb[4*i +: 4];
                w_sel_addr  = m_addr[32*i +: 32];
                w_sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end

    assign sram_en    = w_gnt;
    assign sram_wen   = (w_gnt && w_sel_wr) ? w_sel_wstrb : 4'b0000;
    assign sram_wdata = w_sel_wdata;
    assign sram_addr  = (MAP_EN != 0 && w_sel_addr[31:30] == 2'b10) ?
                        {3'b000, w_sel_addr[28:0]} : w_sel_addr;
    assign m_rdata    = sram_rdata;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_addr_ok[i] = w_gnt && (w_gnt_id == CW'(i));
            m_data_ok[i] = resetn && r_tag_vld[RD_LAT-1] && (r_tag_id[RD_LAT-1] == CW'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr  <= '0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_gnt;
            r_tag_id[0]  <= w_gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            if (w_gnt)
                r_rr_ptr <= (w_gnt_id == CW'(N_CH - 1)) ? '0 : w_gnt_id + CW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three configurations share one clock and reset.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // a: N_CH=2 RD_LAT=1 fixed priority, mapping on
    logic [1:0]  a_req, a_wr, a_addr_ok, a_data_ok;
    logic [7:0]  a_wstrb;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_srd, a_saddr, a_swdata;
    logic        a_sen;
    logic [3:0]  a_swen;
    // b: N_CH=3 RD_LAT=3 round robin, mapping on
    logic [2:0]  b_req, b_wr, b_addr_ok, b_data_ok;
    logic [11:0] b_wstrb;
    logic [95:0] b_addr, b_wdata;
    logic [31:0] b_rdata, b_srd, b_saddr, b_swdata;
    logic        b_sen;
    logic [3:0]  b_swen;
    // c: N_CH=2 RD_LAT=2 round robin, mapping off
    logic [1:0]  c_req, c_wr, c_addr_ok, c_data_ok;
    logic [7:0]  c_wstrb;
    logic [63:0] c_addr, c_wdata;
    logic [31:0] c_rdata, c_srd, c_saddr, c_swdata;
    logic        c_sen;
    logic [3:0]  c_swen;

    mem_port_arbiter #(.N_CH(2), .RD_LAT(1), .ARB_MODE(0), .MAP_EN(1)) a_dut (
        .clk(clk), .resetn(resetn), .m_req(a_req), .m_wr(a_wr), .m_wstrb(a_wstrb),
        .m_addr(a_addr), .m_wdata(a_wdata), .m_addr_ok(a_addr_ok), .m_data_ok(a_data_ok),
        .m_rdata(a_rdata), .sram_en(a_sen), .sram_wen(a_swen), .sram_addr(a_saddr),
        .sram_wdata(a_swdata), .sram_rdata(a_srd));

    mem_port_arbiter #(.N_CH(3), .RD_LAT(3), .ARB_MODE(1), .MAP_EN(1)) b_dut (
        .clk(clk), .resetn(resetn), .m_req(b_req), .m_wr(b_wr), .m_wstrb(b_wstrb),
        .m_addr(b_addr), .m_wdata(b_wdata), .m_addr_ok(b_addr_ok), .m_data_ok(b_data_ok),
        .m_rdata(b_rdata), .sram_en(b_sen), .sram_wen(b_swen), .sram_addr(b_saddr),
        .sram_wdata(b_swdata), .sram_rdata(b_srd));

    mem_port_arbiter #(.N_CH(2), .RD_LAT(2), .ARB_MODE(1), .MAP_EN(0)) c_dut (
        .clk(clk), .resetn(resetn), .m_req(c_req), .m_wr(c_wr), .m_wstrb(c_wstrb),
        .m_addr(c_addr), .m_wdata(c_wdata), .m_addr_ok(c_addr_ok), .m_data_ok(c_data_ok),
        .m_rdata(c_rdata), .sram_en(c_sen), .sram_wen(c_swen), .sram_addr(c_saddr),
        .sram_wdata(c_swdata), .sram_rdata(c_srd));

    task automatic test_reset();
        @(negedge clk);
        a_req = 2'b11; a_wr = 2'b11; a_wstrb = 8'hFF;
        b_req = 3'b111; c_req = 2'b11;
        #1;
        vectors++; if (a_addr_ok !== 2'b00) begin miscompares++; $display("FAIL rst_a_addr_ok got %b exp 00", a_addr_ok); end
        vectors++; if (a_data_ok !== 2'b00) begin miscompares++; $display("FAIL rst_a_data_ok got %b exp 00", a_data_ok); end
        vectors++; if (a_sen !== 1'b0) begin miscompares++; $display("FAIL rst_a_sram_en got %b exp 0", a_sen); end
        vectors++; if (a_swen !== 4'b0000) begin miscompares++; $display("FAIL rst_a_sram_wen got %b exp 0000", a_swen); end
        vectors++; if (b_addr_ok !== 3'b000) begin miscompares++; $display("FAIL rst_b_addr_ok got %b exp 000", b_addr_ok); end
        vectors++; if (b_sen !== 1'b0) begin miscompares++; $display("FAIL rst_b_sram_en got %b exp 0", b_sen); end
        vectors++; if (c_addr_ok !== 2'b00) begin miscompares++; $display("FAIL rst_c_addr_ok got %b exp 00", c_addr_ok); end
        vectors++; if (c_dut.r_rr_ptr !== 1'b0) begin miscompares++; $display("FAIL rst_c_rr_ptr got %b exp 0", c_dut.r_rr_ptr); end
        @(negedge clk);
        a_req = '0; a_wr = '0; a_wstrb = '0; b_req = '0; c_req = '0;
        resetn = 1'b1;
    endtask

    task automatic test_read_map();
        @(negedge clk);
        a_req = 2'b01; a_wr = 2'b00; a_addr[31:0] = 32'h8000_0010; a_srd = 32'h0;
        #1;
        vectors++; if (a_addr_ok !== 2'b01) begin miscompares++; $display("FAIL rd_addr_ok got %b exp 01", a_addr_ok); end
        vectors++; if (a_saddr !== 32'h0000_0010) begin miscompares++; $display("FAIL rd_sram_addr got %h exp 00000010", a_saddr); end
        vectors++; if (a_sen !== 1'b1) begin miscompares++; $display("FAIL rd_sram_en got %b exp 1", a_sen); end
        vectors++; if (a_swen !== 4'b0000) begin miscompares++; $display("FAIL rd_sram_wen got %b exp 0000", a_swen); end
        vectors++; if (a_data_ok !== 2'b00) begin miscompares++; $display("FAIL rd_early_data_ok got %b exp 00", a_data_ok); end
        @(negedge clk);
        a_req = 2'b00; a_srd = 32'hCAFE_0001;
        #1;
        vectors++; if (a_data_ok !== 2'b01) begin miscompares++; $display("FAIL rd_data_ok got %b exp 01", a_data_ok); end
        vectors++; if (a_rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL rd_rdata got %h exp cafe0001", a_rdata); end
        vectors++; if (a_sen !== 1'b0) begin miscompares++; $display("FAIL rd_idle_sram_en got %b exp 0", a_sen); end
        @(negedge clk);
        #1;
        vectors++; if (a_data_ok !== 2'b00) begin miscompares++; $display("FAIL rd_late_data_ok got %b exp 00", a_data_ok); end
    endtask

    // ch0 held with ch1: ch0 wins every cycle, and its responses overlap new grants.
    task automatic test_fixed_prio();
        logic [1:0] exp_aok, exp_dok;
        a_wr = 2'b01;
        a_wstrb = {4'b1111, 4'b0101};
        a_addr = {32'h8000_0100, 32'h0000_1000};
        a_wdata = {32'h9999_8888, 32'h1111_2222};
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            a_req = (t < 3) ? 2'b11 : 2'b00;
            a_srd = 32'h5000_0000 + 32'(t);
            #1;
            exp_aok = (t < 3) ? 2'b01 : 2'b00;
            exp_dok = (t >= 1 && t <= 3) ? 2'b01 : 2'b00;
            vectors++; if (a_addr_ok !== exp_aok) begin miscompares++; $display("FAIL fp_addr_ok t=%0d got %b exp %b", t, a_addr_ok, exp_aok); end
            vectors++; if (a_data_ok !== exp_dok) begin miscompares++; $display("FAIL fp_data_ok t=%0d got %b exp %b", t, a_data_ok, exp_dok); end
            if (t < 3) begin
                vectors++; if (a_swen !== 4'b0101) begin miscompares++; $display("FAIL fp_sram_wen t=%0d got %b exp 0101", t, a_swen); end
                vectors++; if (a_swdata !== 32'h1111_2222) begin miscompares++; $display("FAIL fp_sram_wdata t=%0d got %h exp 11112222", t, a_swdata); end
                vectors++; if (a_saddr !== 32'h0000_1000) begin miscompares++; $display("FAIL fp_sram_addr t=%0d got %h exp 00001000", t, a_saddr); end
            end
            if (exp_dok != 2'b00) begin
                vectors++; if (a_rdata !== 32'h5000_0000 + 32'(t)) begin miscompares++; $display("FAIL fp_rdata t=%0d got %h exp %h", t, a_rdata, 32'h5000_0000 + 32'(t)); end
            end
        end
        a_wr = 2'b00; a_wstrb = '0;
    endtask

    task automatic test_passthrough();
        logic [31:0] pt_in  [4] = '{32'h0040_0000, 32'hC000_0000, 32'h7FFF_FFFC, 32'hA000_0004};
        logic [31:0] pt_exp [4] = '{32'h0040_0000, 32'hC000_0000, 32'h7FFF_FFFC, 32'h0000_0004};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req = 2'b10; a_addr[63:32] = pt_in[i];
            #1;
            vectors++; if (a_addr_ok !== 2'b10) begin miscompares++; $display("FAIL pt_addr_ok i=%0d got %b exp 10", i, a_addr_ok); end
            vectors++; if (a_saddr !== pt_exp[i]) begin miscompares++; $display("FAIL pt_sram_addr i=%0d got %h exp %h", i, a_saddr, pt_exp[i]); end
        end
        @(negedge clk);
        a_req = 2'b00; c_req = 2'b10; c_addr[63:32] = 32'h8000_0000;
        #1;
        vectors++; if (c_addr_ok !== 2'b10) begin miscompares++; $display("FAIL nomap_addr_ok got %b exp 10", c_addr_ok); end
        vectors++; if (c_saddr !== 32'h8000_0000) begin miscompares++; $display("FAIL nomap_sram_addr got %h exp 80000000", c_saddr); end
        @(negedge clk);
        c_req = 2'b00;
        #1;
        vectors++; if (c_data_ok !== 2'b00) begin miscompares++; $display("FAIL nomap_early_data_ok got %b exp 00", c_data_ok); end
        @(negedge clk);
        c_srd = 32'h1234_5678;
        #1;
        vectors++; if (c_data_ok !== 2'b10) begin miscompares++; $display("FAIL nomap_data_ok got %b exp 10", c_data_ok); end
        vectors++; if (c_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL nomap_rdata got %h exp 12345678", c_rdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_aok, exp_dok;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            b_req = (t < 6) ? 3'b111 : 3'b000;
            #1;
            exp_aok = (t < 6) ? 3'(3'b001 << (t % 3)) : 3'b000;
            exp_dok = (t >= 3) ? 3'(3'b001 << ((t - 3) % 3)) : 3'b000;
            vectors++; if (b_addr_ok !== exp_aok) begin miscompares++; $display("FAIL rr_addr_ok t=%0d got %b exp %b", t, b_addr_ok, exp_aok); end
            vectors++; if (b_data_ok !== exp_dok) begin miscompares++; $display("FAIL rr_data_ok t=%0d got %b exp %b", t, b_data_ok, exp_dok); end
        end
    endtask

    // Pointer starts at 0: partial request sets exercise skip-ahead and wrap.
    task automatic test_rr_wrap();
        logic [2:0] reqs [4] = '{3'b110, 3'b111, 3'b011, 3'b011};
        logic [2:0] gnts [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
        logic [2:0] exp_aok, exp_dok;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            b_req = (t < 4) ? reqs[t] : 3'b000;
            #1;
            exp_aok = (t < 4) ? gnts[t] : 3'b000;
            exp_dok = (t >= 3) ? gnts[t-3] : 3'b000;
            vectors++; if (b_addr_ok !== exp_aok) begin miscompares++; $display("FAIL rrw_addr_ok t=%0d got %b exp %b", t, b_addr_ok, exp_aok); end
            vectors++; if (b_data_ok !== exp_dok) begin miscompares++; $display("FAIL rrw_data_ok t=%0d got %b exp %b", t, b_data_ok, exp_dok); end
        end
    endtask

    task automatic test_write_lat3();
        @(negedge clk);
        b_req = 3'b010; b_wr = 3'b010; b_wstrb[7:4] = 4'b0011;
        b_addr[63:32] = 32'hBFC0_0000; b_wdata[63:32] = 32'hDEAD_BEEF;
        #1;
        vectors++; if (b_addr_ok !== 3'b010) begin miscompares++; $display("FAIL wr_addr_ok got %b exp 010", b_addr_ok); end
        vectors++; if (b_swen !== 4'b0011) begin miscompares++; $display("FAIL wr_sram_wen got %b exp 0011", b_swen); end
        vectors++; if (b_saddr !== 32'h1FC0_0000) begin miscompares++; $display("FAIL wr_sram_addr got %h exp 1fc00000", b_saddr); end
        vectors++; if (b_swdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_sram_wdata got %h exp deadbeef", b_swdata); end
        @(negedge clk);
        b_req = 3'b001; b_wr = 3'b000; b_addr[31:0] = 32'h0000_0040;
        #1;
        vectors++; if (b_addr_ok !== 3'b001) begin miscompares++; $display("FAIL wr_rd_addr_ok got %b exp 001", b_addr_ok); end
        vectors++; if (b_swen !== 4'b0000) begin miscompares++; $display("FAIL wr_rd_sram_wen got %b exp 0000", b_swen); end
        vectors++; if (b_saddr !== 32'h0000_0040) begin miscompares++; $display("FAIL wr_rd_sram_addr got %h exp 00000040", b_saddr); end
        @(negedge clk);
        b_req = 3'b000;
        #1;
        vectors++; if (b_data_ok !== 3'b000) begin miscompares++; $display("FAIL wr_c2_data_ok got %b exp 000", b_data_ok); end
        @(negedge clk);
        b_srd = 32'h3333_3333;
        #1;
        vectors++; if (b_data_ok !== 3'b010) begin miscompares++; $display("FAIL wr_c3_data_ok got %b exp 010", b_data_ok); end
        vectors++; if (b_rdata !== 32'h3333_3333) begin miscompares++; $display("FAIL wr_c3_rdata got %h exp 33333333", b_rdata); end
        @(negedge clk);
        b_srd = 32'h4444_4444;
        #1;
        vectors++; if (b_data_ok !== 3'b001) begin miscompares++; $display("FAIL wr_c4_data_ok got %b exp 001", b_data_ok); end
        vectors++; if (b_rdata !== 32'h4444_4444) begin miscompares++; $display("FAIL wr_c4_rdata got %h exp 44444444", b_rdata); end
        @(negedge clk);
        #1;
        vectors++; if (b_data_ok !== 3'b000) begin miscompares++; $display("FAIL wr_c5_data_ok got %b exp 000", b_data_ok); end
    endtask

    // Pointer is 1 when reset hits; after release ch0 must win a contested request.
    task automatic test_reset_inflight();
        @(negedge clk);
        c_req = 2'b11;
        #1;
        vectors++; if (c_addr_ok !== 2'b01) begin miscompares++; $display("FAIL ri_c0_addr_ok got %b exp 01", c_addr_ok); end
        @(negedge clk);
        #1;
        vectors++; if (c_addr_ok !== 2'b10) begin miscompares++; $display("FAIL ri_c1_addr_ok got %b exp 10", c_addr_ok); end
        #1;
        resetn = 1'b0;
        #1;
        vectors++; if (c_addr_ok !== 2'b00) begin miscompares++; $display("FAIL ri_rst_addr_ok got %b exp 00", c_addr_ok); end
        vectors++; if (c_dut.r_rr_ptr !== 1'b0) begin miscompares++; $display("FAIL ri_rst_rr_ptr got %b exp 0", c_dut.r_rr_ptr); end
        @(negedge clk);
        #1;
        vectors++; if (c_data_ok !== 2'b00) begin miscompares++; $display("FAIL ri_c2_data_ok got %b exp 00", c_data_ok); end
        vectors++; if (c_sen !== 1'b0) begin miscompares++; $display("FAIL ri_c2_sram_en got %b exp 0", c_sen); end
        vectors++; if (c_swen !== 4'b0000) begin miscompares++; $display("FAIL ri_c2_sram_wen got %b exp 0000", c_swen); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        vectors++; if (c_addr_ok !== 2'b01) begin miscompares++; $display("FAIL ri_c3_addr_ok got %b exp 01", c_addr_ok); end
        vectors++; if (c_data_ok !== 2'b00) begin miscompares++; $display("FAIL ri_c3_data_ok got %b exp 00", c_data_ok); end
        @(negedge clk);
        c_req = 2'b00;
        #1;
        vectors++; if (c_data_ok !== 2'b00) begin miscompares++; $display("FAIL ri_c4_data_ok got %b exp 00", c_data_ok); end
        @(negedge clk);
        c_srd = 32'hABCD_0000;
        #1;
        vectors++; if (c_data_ok !== 2'b01) begin miscompares++; $display("FAIL ri_c5_data_ok got %b exp 01", c_data_ok); end
        vectors++; if (c_rdata !== 32'hABCD_0000) begin miscompares++; $display("FAIL ri_c5_rdata got %h exp abcd0000", c_rdata); end
        @(negedge clk);
        #1;
        vectors++; if (c_data_ok !== 2'b00) begin miscompares++; $display("FAIL ri_c6_data_ok got %b exp 00", c_data_ok); end
    endtask

    initial begin
        a_req = '0; a_wr = '0; a_wstrb = '0; a_addr = '0; a_wdata = '0; a_srd = '0;
        b_req = '0; b_wr = '0; b_wstrb = '0; b_addr = '0; b_wdata = '0; b_srd = '0;
        c_req = '0; c_wr = '0; c_wstrb = '0; c_addr = '0; c_wdata = '0; c_srd = '0;
        test_reset();
        test_read_map();
        test_fixed_prio();
        test_passthrough();
        test_round_robin();
        test_rr_wrap();
        test_write_lat3();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
